// File: rtl/sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit counter width; a single-bit operand still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full-subtractor cell, the borrow-form twin of the adder's full-adder.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_n.sv
// Bit-serial n-bit subtractor, LSB first, behind a start/busy/done handshake.
module serial_subtractor_n
  import sub_pkg::*;
#(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] D,
  output logic         Bout
);

  localparam int            CW       = cnt_width(n);
  localparam logic [CW-1:0] CNT_LAST = CW'(n - 1);

  state_t          state_q, state_d;
  logic [n-1:0]    a_sh_q, a_sh_d;
  logic [n-1:0]    b_sh_q, b_sh_d;
  logic [n-1:0]    d_q, d_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            borrow_q, borrow_d;
  logic            bout_q, bout_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            diff;
  logic            borrow_nx;
  logic [n-1:0]    d_shift;

  full_subtractor u_fs (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (borrow_q),
    .d    (diff),
    .bout (borrow_nx)
  );

  // Each difference bit enters at the MSB so bit 0 lands at D[0] after n shifts.
  generate
    if (n == 1) begin : g_d_one
      assign d_shift = diff;
    end else begin : g_d_many
      assign d_shift = {diff, d_q[n-1:1]};
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    d_d      = d_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d   = A;
          b_sh_d   = B;
          d_d      = '0;
          cnt_d    = '0;
          borrow_d = 1'b0;
          busy_d   = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        d_d      = d_shift;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        borrow_d = borrow_nx;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          bout_d  = borrow_nx;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      d_q      <= d_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign D    = d_q;
  assign Bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor_n.sv
// Self-checking bench for serial_subtractor_n at n = 1, 4 and 8 against an arithmetic model.
module tb_serial_subtractor_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       st1 = 1'b0, a1 = 1'b0, b1 = 1'b0;
  logic       busy1, done1, bout1;
  logic       d1;
  logic       st4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, bout4;
  logic [3:0] d4;
  logic       st8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, bout8;
  logic [7:0] d8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_subtractor_n #(.n(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .A(a1), .B(b1),
    .busy(busy1), .done(done1), .D(d1), .Bout(bout1)
  );
  serial_subtractor_n #(.n(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(st4), .A(a4), .B(b4),
    .busy(busy4), .done(done4), .D(d4), .Bout(bout4)
  );
  serial_subtractor_n #(.n(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .D(d8), .Bout(bout8)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // sel: 0 -> n=1, 1 -> n=4, 2 -> n=8
  task automatic drive(input int sel, input logic s, input logic [7:0] a, input logic [7:0] b);
    case (sel)
      0: begin st1 = s; a1 = a[0];   b1 = b[0];   end
      1: begin st4 = s; a4 = a[3:0]; b4 = b[3:0]; end
      default: begin st8 = s; a8 = a; b8 = b; end
    endcase
  endtask

  function automatic logic [7:0] get_d(input int sel);
    case (sel)
      0: return {7'b0, d1};
      1: return {4'b0, d4};
      default: return d8;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0: return busy1;
      1: return busy4;
      default: return busy8;
    endcase
  endfunction

  function automatic logic get_done(input int sel);
    case (sel)
      0: return done1;
      1: return done4;
      default: return done8;
    endcase
  endfunction

  function automatic logic get_bout(input int sel);
    case (sel)
      0: return bout1;
      1: return bout4;
      default: return bout8;
    endcase
  endfunction

  // Reference: {Bout, D} = {0, A} - {0, B} on w-bit unsigned operands.
  function automatic logic [8:0] ref_sub(input int w, input logic [7:0] a, input logic [7:0] b);
    int mask = (1 << w) - 1;
    int ai = int'(a) & mask;
    int bi = int'(b) & mask;
    return {(ai < bi) ? 1'b1 : 1'b0, 8'((ai - bi) & mask)};
  endfunction

  // One full transaction: start for a single cycle, then wait for done (bounded).
  task automatic op(input int sel, input int w, input logic [7:0] a, input logic [7:0] b);
    int          edges;
    int          mask;
    logic [8:0]  expv;
    logic [7:0]  obs_d;
    mask = (1 << w) - 1;
    expv = ref_sub(w, a, b);
    @(negedge clk);
    drive(sel, 1'b1, a, b);
    @(negedge clk);
    drive(sel, 1'b0, 8'($urandom), 8'($urandom));
    chk("busy_after_accept", 8'(get_busy(sel)), 8'd1);
    edges = 0;
    while (!get_done(sel) && edges < 40) begin
      @(negedge clk);
      edges++;
      chk("busy_done_exclusive", 8'(get_busy(sel) & get_done(sel)), 8'd0);
    end
    obs_d = get_d(sel);
    chk("latency_edges", 8'(edges), 8'(w));
    chk("diff", obs_d, expv[7:0]);
    chk("borrow", 8'(get_bout(sel)), 8'(expv[8]));
    chk("adder_crosscheck", 8'((int'(obs_d) + (int'(b) & mask)) & mask), 8'(int'(a) & mask));
    chk("busy_at_done", 8'(get_busy(sel)), 8'd0);
    @(negedge clk);
    chk("done_single_pulse", 8'(get_done(sel)), 8'd0);
    chk("idle_not_busy", 8'(get_busy(sel)), 8'd0);
    chk("result_held", get_d(sel), expv[7:0]);
  endtask

  initial begin
    logic [3:0] qa[$];
    logic [3:0] qb[$];
    logic [8:0] expv;

    #3;
    chk("rst_busy", 8'(busy4), 8'd0);
    chk("rst_done", 8'(done4), 8'd0);
    chk("rst_d", 8'(d4), 8'd0);
    chk("rst_bout", 8'(bout4), 8'd0);
    chk("rst_d8", d8, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    op(1, 4, 8'h0F, 8'h01);
    op(1, 4, 8'h06, 8'h05);
    op(1, 4, 8'h04, 8'h09);
    op(1, 4, 8'h07, 8'h08);

    // Abort in the second SHIFT cycle; Bout is 1 from the previous result.
    @(negedge clk);
    drive(1, 1'b1, 8'h0C, 8'h03);
    @(negedge clk);
    drive(1, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 8'(busy4), 8'd0);
    chk("abort_done", 8'(done4), 8'd0);
    chk("abort_d", 8'(d4), 8'd0);
    chk("abort_bout", 8'(bout4), 8'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      chk("abort_no_done", 8'(done4), 8'd0);
    end
    op(1, 4, 8'h0A, 8'h03);

    // start held high: accepts every n+2 = 6 edges, each with its own operands.
    for (int t = 0; t < 24; t++) begin
      drive(1, 1'b1, 8'($urandom), 8'($urandom));
      if (t % 6 == 0) begin
        qa.push_back(a4);
        qb.push_back(b4);
      end
      @(negedge clk);
      chk("cont_busy", 8'(busy4), 8'((t % 6) < 4));
      if (t % 6 == 4) begin
        expv = ref_sub(4, {4'b0, qa[0]}, {4'b0, qb[0]});
        void'(qa.pop_front());
        void'(qb.pop_front());
        chk("cont_done", 8'(done4), 8'd1);
        chk("cont_diff", 8'(d4), expv[7:0]);
        chk("cont_borrow", 8'(bout4), 8'(expv[8]));
      end else begin
        chk("cont_no_done", 8'(done4), 8'd0);
      end
    end
    drive(1, 1'b0, 8'h00, 8'h00);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        op(1, 4, 8'(a), 8'(b));

    op(0, 1, 8'h00, 8'h01);
    op(0, 1, 8'h01, 8'h00);
    op(0, 1, 8'h01, 8'h01);
    op(0, 1, 8'h00, 8'h00);

    op(2, 8, 8'h00, 8'hFF);
    op(2, 8, 8'hFF, 8'h00);
    op(2, 8, 8'h80, 8'h80);
    for (int i = 0; i < 20; i++)
      op(2, 8, 8'($urandom), 8'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
